// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B bit decoder: state encoding and
// recommended pulse-width tick constants for a 64 MHz system clock.
package ws2812b_pkg;

    localparam int PIXEL_BITS_DEFAULT = 24;

    typedef logic [1:0] state_t;

    localparam state_t LOCKOUT = 2'd0;
    localparam state_t READY   = 2'd1;
    localparam state_t HIGH    = 2'd2;

    // Nominal WS2812B high times and decision points at 64 MHz.
    localparam int T0H_TICKS       = 26;
    localparam int T1H_TICKS       = 51;
    localparam int THRESHOLD_TICKS = 38;
    localparam int MAX_HIGH_TICKS  = 128;

endpackage

// File: rtl/ws2812b_bit_decoder.sv
// WS2812B serial decoder: measures each high pulse against a threshold,
// assembles MSB-first pixel words and frames them using the idle flag.
module ws2812b_bit_decoder
    import ws2812b_pkg::*;
#(
    parameter int PIXEL_BITS = PIXEL_BITS_DEFAULT,
    parameter int IDX_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic                  idle,
    input  logic [CNT_W-1:0]      bit_threshold_ticks,
    input  logic [CNT_W-1:0]      max_high_ticks,
    output logic [PIXEL_BITS-1:0] pixel_data,
    output logic [IDX_W-1:0]      pixel_index,
    output logic                  pixel_valid,
    output logic                  frame_done,
    output logic                  bit_error
);

    localparam int BC_W = $clog2(PIXEL_BITS + 1);

    state_t                state;
    logic [CNT_W-1:0]      high_cnt;
    logic [BC_W-1:0]       bit_cnt;
    logic [PIXEL_BITS-1:0] shift_reg;
    logic [IDX_W-1:0]      frame_idx;

    logic [CNT_W-1:0]      high_inc;
    logic                  decoded_bit;
    logic [PIXEL_BITS-1:0] shift_next;
    logic                  last_bit;

    assign high_inc    = (&high_cnt) ? high_cnt : high_cnt + CNT_W'(1);
    assign decoded_bit = (high_cnt >= bit_threshold_ticks);
    assign shift_next  = {shift_reg[PIXEL_BITS-2:0], decoded_bit};
    assign last_bit    = (bit_cnt == BC_W'(PIXEL_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOCKOUT;
            high_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            frame_idx   <= '0;
            pixel_data  <= '0;
            pixel_index <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;

            case (state)
                LOCKOUT: begin
                    if (idle) begin
                        state <= READY;
                    end
                end

                READY: begin
                    // Idle lags din by a cycle, so a new pulse may start in the same cycle.
                    if (idle) begin
                        if (bit_cnt != '0) begin
                            bit_error <= 1'b1;
                            bit_cnt   <= '0;
                        end
                        if (frame_idx != '0) begin
                            frame_done <= 1'b1;
                            frame_idx  <= '0;
                        end
                    end
                    if (din) begin
                        if (max_high_ticks <= CNT_W'(1)) begin
                            bit_error <= 1'b1;
                            bit_cnt   <= '0;
                            shift_reg <= '0;
                            state     <= LOCKOUT;
                        end else begin
                            high_cnt <= CNT_W'(1);
                            state    <= HIGH;
                        end
                    end
                end

                HIGH: begin
                    if (din) begin
                        if (high_inc >= max_high_ticks) begin
                            bit_error <= 1'b1;
                            bit_cnt   <= '0;
                            shift_reg <= '0;
                            high_cnt  <= '0;
                            state     <= LOCKOUT;
                        end else begin
                            high_cnt <= high_inc;
                        end
                    end else begin
                        shift_reg <= shift_next;
                        high_cnt  <= '0;
                        state     <= READY;
                        if (last_bit) begin
                            pixel_data  <= shift_next;
                            pixel_index <= frame_idx;
                            pixel_valid <= 1'b1;
                            bit_cnt     <= '0;
                            if (frame_idx != '1) begin
                                frame_idx <= frame_idx + IDX_W'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end
                end

                default: begin
                    state <= LOCKOUT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_bit_decoder.sv
// Randomized scoreboard bench for ws2812b_bit_decoder: a pulse-level model
// predicts every strobe and the cycle it must appear in.
module tb_ws2812b_bit_decoder;
    import ws2812b_pkg::*;

    localparam int PB = 24;
    localparam int IW = 8;
    localparam int CW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          din   = 1'b0;
    logic          idle  = 1'b0;
    logic [CW-1:0] thr_ticks = CW'(THRESHOLD_TICKS);
    logic [CW-1:0] max_ticks = CW'(MAX_HIGH_TICKS);
    logic [PB-1:0] pixel_data;
    logic [IW-1:0] pixel_index;
    logic          pixel_valid;
    logic          frame_done;
    logic          bit_error;

    ws2812b_bit_decoder #(
        .PIXEL_BITS(PB),
        .IDX_W     (IW),
        .CNT_W     (CW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .din                (din),
        .idle               (idle),
        .bit_threshold_ticks(thr_ticks),
        .max_high_ticks     (max_ticks),
        .pixel_data         (pixel_data),
        .pixel_index        (pixel_index),
        .pixel_valid        (pixel_valid),
        .frame_done         (frame_done),
        .bit_error          (bit_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // kind: 0 pixel_valid, 1 frame_done, 2 bit_error
    typedef struct {
        int            kind;
        logic [PB-1:0] data;
        int            index;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model: lockout flag, bits collected so far, frame index.
    bit locked = 1'b1;
    bit model_bits[$];
    int frame_idx = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushEvent(input int kind, input logic [PB-1:0] data, input int index, input int when);
        exp_t e;
        e.kind  = kind;
        e.data  = data;
        e.index = index;
        e.cyc   = when;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic d, input logic i, output int c);
        @(posedge clk);
        #1;
        din  = d;
        idle = i;
        c    = cyc;
    endtask

    // One WS2812B bit: high_len cycles of din=1 followed by low_len cycles of din=0.
    task automatic applyStimulus(input int high_len, input int low_len);
        int            c;
        int            start;
        logic [PB-1:0] v;
        step(1'b1, 1'b0, start);
        if (!locked) begin
            if (high_len >= int'(max_ticks)) begin
                pushEvent(2, '0, 0, start + int'(max_ticks));
                model_bits.delete();
                locked = 1'b1;
            end else begin
                model_bits.push_back(high_len >= int'(thr_ticks));
                if (model_bits.size() == PB) begin
                    v = '0;
                    for (int k = 0; k < PB; k++) v[PB-1-k] = model_bits[k];
                    pushEvent(0, v, (frame_idx > 255) ? 255 : frame_idx, start + high_len + 1);
                    frame_idx++;
                    model_bits.delete();
                end
            end
        end
        for (int k = 1; k < high_len; k++) step(1'b1, 1'b0, c);
        for (int k = 0; k < low_len; k++) step(1'b0, 1'b0, c);
    endtask

    task automatic idlePeriod(input int n);
        int c;
        int act;
        step(1'b0, 1'b1, c);
        act    = locked ? c + 2 : c + 1;
        locked = 1'b0;
        if (frame_idx != 0) pushEvent(1, '0, 0, act);
        if (model_bits.size() != 0) pushEvent(2, '0, 0, act);
        frame_idx = 0;
        model_bits.delete();
        for (int k = 1; k < n; k++) step(1'b0, 1'b1, c);
        step(1'b0, 1'b0, c);
    endtask

    task automatic sendPixel(input logic [PB-1:0] v, input int h1, input int h0, input int low_len);
        for (int b = PB - 1; b >= 0; b--) applyStimulus(v[b] ? h1 : h0, low_len);
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, " pixel_data"}, 32'(pixel_data), 32'h0);
        checkOutput({tag, " pixel_index"}, 32'(pixel_index), 32'h0);
        checkOutput({tag, " pixel_valid"}, 32'(pixel_valid), 32'h0);
        checkOutput({tag, " frame_done"}, 32'(frame_done), 32'h0);
        checkOutput({tag, " bit_error"}, 32'(bit_error), 32'h0);
    endtask

    task automatic checkStrobe(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected strobe: kind=%0d at cycle %0d, none expected", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            checkOutput("strobe kind", 32'(kind), 32'(e.kind));
            checkOutput("strobe cycle", 32'(cyc), 32'(e.cyc));
            if (kind == 0 && e.kind == 0) begin
                checkOutput("pixel_data", 32'(pixel_data), 32'(e.data));
                checkOutput("pixel_index", 32'(pixel_index), 32'(e.index));
            end
        end
    endtask

    // Monitor: flags overdue expectations, then matches each strobe to the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL missing strobe: kind=%0d expected at cycle %0d, now %0d",
                         exp_q[0].kind, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (pixel_valid) checkStrobe(0);
            if (frame_done) checkStrobe(1);
            if (bit_error) checkStrobe(2);
        end
    end

    initial begin
        int            c;
        int            npix;
        int            h;
        int            r;
        logic [PB-1:0] v;

        repeat (3) @(posedge clk);
        #1;
        checkZeroOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] pulses before first idle must be ignored");
        sendPixel(24'hFFFFFF, T1H_TICKS, T0H_TICKS, 40);

        $display("[TB] first frame: 0xA5C3F0 plus two random pixels");
        idlePeriod(4);
        sendPixel(24'hA5C3F0, T1H_TICKS, T0H_TICKS, 40);
        sendPixel(24'($urandom()), T1H_TICKS, T0H_TICKS, 40);
        sendPixel(24'($urandom()), T1H_TICKS, T0H_TICKS, 40);
        idlePeriod(4);

        $display("[TB] partial pixel discarded on idle, then clean pixel");
        for (int b = 0; b < 10; b++) applyStimulus(($urandom_range(0, 1) == 1) ? T1H_TICKS : T0H_TICKS, 40);
        idlePeriod(4);
        sendPixel(24'h0F1E2D, T1H_TICKS, T0H_TICKS, 40);
        idlePeriod(4);

        $display("[TB] overlong pulse forces lockout");
        applyStimulus(200, 10);
        sendPixel(24'h123456, T1H_TICKS, T0H_TICKS, 40);
        idlePeriod(4);
        sendPixel(24'h3C5AF1, T1H_TICKS, T0H_TICKS, 40);

        $display("[TB] threshold boundary 38 vs 37 ticks");
        sendPixel(24'hAAAAAA, THRESHOLD_TICKS, THRESHOLD_TICKS - 1, 12);
        idlePeriod(4);

        $display("[TB] randomized frames with short timings");
        thr_ticks = CW'(10);
        max_ticks = CW'(20);
        for (int f = 0; f < 6; f++) begin
            idlePeriod(3);
            npix = $urandom_range(1, 3);
            for (int p = 0; p < npix; p++) begin
                v = 24'($urandom());
                for (int b = PB - 1; b >= 0; b--) begin
                    r = $urandom_range(0, 63);
                    if (r == 0) h = $urandom_range(20, 23);
                    else h = v[b] ? $urandom_range(10, 19) : $urandom_range(1, 9);
                    if (r == 1) idlePeriod(3);
                    applyStimulus(h, $urandom_range(1, 5));
                end
            end
        end
        idlePeriod(3);

        $display("[TB] reset asserted mid-pixel");
        thr_ticks = CW'(THRESHOLD_TICKS);
        max_ticks = CW'(MAX_HIGH_TICKS);
        sendPixel(24'h5A5A5A, T1H_TICKS, T0H_TICKS, 20);
        for (int b = 0; b < 10; b++) applyStimulus(T1H_TICKS, 20);
        repeat (3) step(1'b1, 1'b0, c);
        #2;
        rst_n = 1'b0;
        #1;
        checkZeroOutputs("mid-pixel reset");
        locked    = 1'b1;
        frame_idx = 0;
        model_bits.delete();
        repeat (2) @(negedge clk);
        din   = 1'b0;
        rst_n = 1'b1;
        sendPixel(24'hC0FFEE, T1H_TICKS, T0H_TICKS, 20);
        idlePeriod(4);
        sendPixel(24'h00FF81, T1H_TICKS, T0H_TICKS, 20);
        idlePeriod(4);

        repeat (5) step(1'b0, 1'b0, c);
        checkOutput("pending expectations", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
